// File: rtl/fp32_pkg.sv
// fp32_pkg: shared single-precision constants, FSM states and operand classes
package fp32_pkg;
   localparam int FP_BIAS = 127;
   localparam int FP_EXP_MAX = 255;
   localparam logic [31:0] FP_QNAN = 32'h7FC00000;
   localparam int FP_MANT_W = 23;
   localparam int FP_EXP_W = 8;
   typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_RND, S_DONE} state_t;
   typedef enum logic [1:0] {CL_ZERO, CL_NORMAL, CL_INF, CL_NAN} cls_t;
endpackage

// File: rtl/fp32_round_pack.sv
// fp32_round_pack: round-to-nearest-even, exponent clamp and IEEE-754 packing
module fp32_round_pack
   import fp32_pkg::*;
(
   input  logic              sign,
   input  logic signed [9:0] exp,
   input  logic [22:0]       man,
   input  logic              guard,
   input  logic              sticky,
   input  logic [1:0]        cls,
   output logic [31:0]       res
);
   logic [23:0] rm;
   logic signed [9:0] er;
   logic ovf, unf;
   // a carry out of the rounded mantissa leaves it all-zero, so only the exponent moves
   assign rm = {1'b0, man} + 24'(guard & (sticky | man[0]));
   assign er = exp + $signed({9'b0, rm[23]});
   assign ovf = er >= $signed(10'(FP_EXP_MAX));
   assign unf = er <= 10'sd0;
   // specials take priority over the range clamp of a normal result
   always_comb
      res = cls == CL_NAN ? FP_QNAN :
            cls == CL_INF || (cls == CL_NORMAL && ovf) ? {sign, {FP_EXP_W{1'b1}}, {FP_MANT_W{1'b0}}} :
            cls == CL_ZERO || unf ? {sign, 31'b0} :
            {sign, er[7:0], rm[22:0]};
endmodule

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: iterative shift-add IEEE-754 single-precision multiplier with valid/ready
module fp_mul_seq
   import fp32_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] res
);
   localparam int B = BITS_PER_CYCLE;
   localparam int MUL_CYCLES = 24 / BITS_PER_CYCLE;
   state_t state;
   cls_t cls, in_cls;
   logic sign, guard, sticky;
   logic [7:0] ea, eb;
   logic [47:0] mcand, acc, pp;
   logic [23:0] mplier;
   logic [4:0] cnt;
   logic signed [9:0] e;
   logic [22:0] man;
   logic [31:0] packed_res;
   logic a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   assign a_max = &a[30:23];
   assign b_max = &b[30:23];
   assign a_nan = a_max && |a[22:0];
   assign b_nan = b_max && |b[22:0];
   assign a_inf = a_max && !(|a[22:0]);
   assign b_inf = b_max && !(|b[22:0]);
   assign a_zero = a[30:23] == '0;
   assign b_zero = b[30:23] == '0;
   assign in_cls = (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) ? CL_NAN :
                   (a_inf || b_inf) ? CL_INF :
                   (a_zero || b_zero) ? CL_ZERO : CL_NORMAL;
   assign pp = mcand * 48'(mplier[B-1:0]);
   fp32_round_pack u_round_pack (
      .sign  (sign),
      .exp   (e),
      .man   (man),
      .guard (guard),
      .sticky(sticky),
      .cls   (cls),
      .res   (packed_res)
   );
   // operation sequencer: accept, shift-add multiply, normalise, round, hold result
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= S_IDLE;
         in_ready <= 1'b0;
         out_valid <= 1'b0;
         res <= '0;
         cls <= CL_ZERO;
         sign <= 1'b0;
         ea <= '0;
         eb <= '0;
         mcand <= '0;
         mplier <= '0;
         acc <= '0;
         cnt <= '0;
         e <= '0;
         man <= '0;
         guard <= 1'b0;
         sticky <= 1'b0;
      end else
         case (state)
            S_IDLE:
               if (in_valid && in_ready) begin
                  sign <= a[31] ^ b[31];
                  ea <= a[30:23];
                  eb <= b[30:23];
                  mcand <= {25'b1, a[22:0]};
                  mplier <= {1'b1, b[22:0]};
                  acc <= '0;
                  cls <= in_cls;
                  cnt <= 5'(MUL_CYCLES - 1);
                  in_ready <= 1'b0;
                  state <= S_MUL;
               end else
                  in_ready <= 1'b1;
            S_MUL: begin
               acc <= acc + pp;
               mcand <= mcand << B;
               mplier <= mplier >> B;
               if (cnt == '0)
                  state <= S_NORM;
               else
                  cnt <= cnt - 1'b1;
            end
            S_NORM: begin
               e <= $signed({2'b0, ea} + {2'b0, eb} - 10'(FP_BIAS) + {9'b0, acc[47]});
               {man, guard} <= acc[47] ? acc[46:23] : acc[45:22];
               sticky <= acc[47] ? |acc[22:0] : |acc[21:0];
               state <= S_RND;
            end
            S_RND: begin
               res <= packed_res;
               out_valid <= 1'b1;
               state <= S_DONE;
            end
            S_DONE:
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready <= 1'b1;
                  state <= S_IDLE;
               end
            default: state <= S_IDLE;
         endcase
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed vectors for fp_mul_seq at 1 and 8 bits per cycle
module tb_fp_mul_seq;
   logic clk = 0, rst_n = 0;
   logic in_valid = 0, out_ready = 0, in_valid8 = 0, out_ready8 = 0;
   logic [31:0] a = 0, b = 0;
   logic in_ready, out_valid, in_ready8, out_valid8;
   logic [31:0] res, res8;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   fp_mul_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .res(res)
   );

   fp_mul_seq #(.BITS_PER_CYCLE(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a), .b(b),
      .out_valid(out_valid8), .out_ready(out_ready8), .res(res8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic start(input string tag, input logic [31:0] x, input logic [31:0] y);
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_irdy"}, in_ready, 1);
      a = x;
      b = y;
      in_valid = 1;
      @(posedge clk);
      #1;
      in_valid = 0;
      a = $urandom;
      b = $urandom;
   endtask

   task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int hold);
      int n = 0;
      logic busy_bad = 0;
      start(tag, x, y);
      while (out_valid !== 1'b1 && n < 60) begin
         if (in_ready !== 1'b0) busy_bad = 1;
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_lat"}, n, 26);
      check({tag, "_busy"}, busy_bad, 0);
      check({tag, "_res"}, res, exp);
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         check({tag, "_hold_ov"}, out_valid, 1);
         check({tag, "_hold_res"}, res, exp);
         check({tag, "_hold_ir"}, in_ready, 0);
      end
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
      check({tag, "_ov_low"}, out_valid, 0);
      check({tag, "_ir_back"}, in_ready, 1);
   endtask

   task automatic release_rst(input string tag);
      @(negedge clk);
      rst_n = 1;
      check({tag, "_ir_pre"}, in_ready, 0);
      @(posedge clk);
      #1;
      check({tag, "_ir_post"}, in_ready, 1);
   endtask

   initial begin
      int n;
      #1;
      check("rst_ov", out_valid, 0);
      check("rst_ir", in_ready, 0);
      check("rst_res", res, 0);
      @(negedge clk);
      @(negedge clk);
      release_rst("init");

      op("2x3", 32'h40000000, 32'h40400000, 32'h40C00000, 0);
      op("1p5xm2p5", 32'h3FC00000, 32'hC0200000, 32'hC0700000, 0);
      op("rnd_a", 32'h3F800001, 32'h3F800001, 32'h3F800002, 0);
      op("rnd_b", 32'h3F800003, 32'h3F800003, 32'h3F800006, 0);
      op("tie_up", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 0);
      op("tie_even", 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 0);
      op("infx0", 32'h7F800000, 32'h00000000, 32'h7FC00000, 0);
      op("minfx2", 32'hFF800000, 32'h40000000, 32'hFF800000, 0);
      op("nan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0);
      op("denorm", 32'h00000001, 32'h40000000, 32'h00000000, 0);
      op("ovf", 32'h7F000000, 32'h40000000, 32'h7F800000, 0);
      op("unf", 32'h00800000, 32'h00800000, 32'h00000000, 0);
      op("unf_neg", 32'h80800000, 32'h00800000, 32'h80000000, 0);
      op("hold", 32'h40000000, 32'h40400000, 32'h40C00000, 10);

      @(negedge clk);
      check("b8_irdy", in_ready8, 1);
      a = 32'h3FC00000;
      b = 32'hC0200000;
      in_valid8 = 1;
      @(posedge clk);
      #1;
      in_valid8 = 0;
      n = 0;
      while (out_valid8 !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("b8_lat", n, 5);
      check("b8_res", res8, 32'hC0700000);
      out_ready8 = 1;
      @(posedge clk);
      #1;
      out_ready8 = 0;
      check("b8_ov_low", out_valid8, 0);

      start("rst_mul", 32'h40000000, 32'h40400000);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 0;
      #1;
      check("rst_mul_ov", out_valid, 0);
      check("rst_mul_ir", in_ready, 0);
      release_rst("rst_mul");

      start("rst_done", 32'h40000000, 32'h40400000);
      n = 0;
      while (out_valid !== 1'b1 && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rst_done_ov_pre", out_valid, 1);
      #2;
      rst_n = 0;
      #1;
      check("rst_done_ov", out_valid, 0);
      check("rst_done_ir", in_ready, 0);
      check("rst_done_res", res, 0);
      release_rst("rst_done");

      op("after_rst", 32'h40000000, 32'h40400000, 32'h40C00000, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
